// File: rtl/tlv5618_model_if.sv
// TLV5618 3-wire serial bus (cs_n/din/sclk) between a DAC writer and the device model.
interface tlv5618_model_if;
    logic cs_n;
    logic din;
    logic sclk;

    modport master (output cs_n, output din, output sclk);
    modport slave  (input  cs_n, input  din, input  sclk);
endinterface

// File: rtl/tlv5618_model.sv
// Device-side model of the TLV5618 serial DAC: oversamples the serial bus, decodes 16-bit frames and updates DAC A/B and the buffer.
// Macro TLV5618_STRICT_LEN_EN: reject frames longer than FRAME_BITS; otherwise keep the last FRAME_BITS bits as the real device does.
module tlv5618_model #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tlv5618_model_if.slave       s_bus,
    output logic [DATA_BITS-1:0] o_dac_a,
    output logic [DATA_BITS-1:0] o_dac_b,
    output logic [DATA_BITS-1:0] o_dac_buf,
    output logic                 o_spd,
    output logic                 o_pwr,
    output logic                 o_frame_done,
    output logic                 o_frame_err,
    output logic [1:0]           o_err_code,
    output logic                 o_busy
);

    localparam int                CNT_W     = 5;
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam int                R1_IDX    = FRAME_BITS - 1;
    localparam int                SPD_IDX   = FRAME_BITS - 2;
    localparam int                PWR_IDX   = FRAME_BITS - 3;
    localparam int                R0_IDX    = FRAME_BITS - 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_cs_sync;
    logic [2:0]              r_sclk_sync;
    logic [1:0]              r_din_sync;
    logic [1:0]              r_fill;
    logic                    r_armed;
    logic [FRAME_BITS-1:0]   r_shift_reg;
    logic [CNT_W-1:0]        r_bit_cnt;

    logic                    w_cs_fall;
    logic                    w_cs_rise;
    logic                    w_sclk_fall;
    logic                    w_din_s;
    logic                    w_clr_cnt;
    logic                    w_shift_en;
    logic                    w_decode;
    logic                    w_short;
    logic                    w_long;
    logic                    w_rsvd;
    logic [1:0]              w_cmd;
    logic [DATA_BITS-1:0]    w_data;

    // Synchronisers plus one extra stage for edge detection; cs_n idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cs_sync   <= 3'b111;
            r_sclk_sync <= 3'b000;
            r_din_sync  <= 2'b00;
            r_fill      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], s_bus.cs_n};
            r_sclk_sync <= {r_sclk_sync[1:0], s_bus.sclk};
            r_din_sync  <= {r_din_sync[0], s_bus.din};
            r_fill      <= {r_fill[0], 1'b1};
            // Only arm once a real (non-reset) high cs_n has been seen, so a
            // reset released mid-frame cannot fake a cs_n falling edge.
            if (r_fill[1] && r_cs_sync[1])
                r_armed <= 1'b1;
        end
    end

    assign w_cs_fall   = r_armed & r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_sclk_fall = r_sclk_sync[2] & ~r_sclk_sync[1];
    assign w_din_s     = r_din_sync[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_cnt   = 1'b0;
        w_shift_en  = 1'b0;
        w_decode    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clr_cnt   = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_shift_en = w_sclk_fall;
                if (w_cs_rise)
                    w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_decode = 1'b1;
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clr_cnt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (w_clr_cnt) begin
            r_bit_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift_reg <= {r_shift_reg[FRAME_BITS-2:0], w_din_s};
            if (r_bit_cnt != '1)
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign w_cmd   = {r_shift_reg[R1_IDX], r_shift_reg[R0_IDX]};
    assign w_data  = r_shift_reg[DATA_BITS-1:0];
    assign w_short = (r_bit_cnt < FRAME_CNT);
    assign w_rsvd  = (w_cmd == 2'b11);
`ifdef TLV5618_STRICT_LEN_EN
    assign w_long  = (r_bit_cnt > FRAME_CNT);
`else
    assign w_long  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dac_a      <= '0;
            o_dac_b      <= '0;
            o_dac_buf    <= '0;
            o_spd        <= 1'b0;
            o_pwr        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_err_code   <= 2'b00;
        end else begin
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_decode) begin
                if (w_short) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= 2'b01;
                end else if (w_long) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= 2'b10;
                end else if (w_rsvd) begin
                    o_frame_err <= 1'b1;
                    o_err_code  <= 2'b11;
                end else begin
                    o_frame_done <= 1'b1;
                    o_spd        <= r_shift_reg[SPD_IDX];
                    o_pwr        <= r_shift_reg[PWR_IDX];
                    case (w_cmd)
                        2'b00: begin
                            o_dac_b   <= w_data;
                            o_dac_buf <= w_data;
                        end
                        2'b01: o_dac_buf <= w_data;
                        // DAC B takes the buffer value from before this frame.
                        2'b10: begin
                            o_dac_a <= w_data;
                            o_dac_b <= o_dac_buf;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_busy = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_tlv5618_model.sv
// Randomised bench for tlv5618_model against a frame-level reference model.
module tb_tlv5618_model;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlv5618_model_if bus ();

    logic [11:0] dac_a, dac_b, dac_buf;
    logic        spd, pwr, frame_done, frame_err, busy;
    logic [1:0]  err_code;

    tlv5618_model dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_bus        (bus),
        .o_dac_a      (dac_a),
        .o_dac_b      (dac_b),
        .o_dac_buf    (dac_buf),
        .o_spd        (spd),
        .o_pwr        (pwr),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err),
        .o_err_code   (err_code),
        .o_busy       (busy)
    );

`ifdef TLV5618_STRICT_LEN_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] m_a, m_b, m_buf;
    logic        m_spd, m_pwr;
    logic [1:0]  m_code;
    int          e_done, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_buf = '0;
        m_spd = 1'b0; m_pwr = 1'b0; m_code = 2'b00;
    endtask

    // Device rules: the last 16 bits clocked in form the word, MSB first.
    task automatic model_frame(input logic [31:0] bits, input int n);
        logic [15:0] w;
        e_done = 0;
        e_err  = 0;
        w = bits[15:0];
        if (n < 16) begin
            e_err = 1; m_code = 2'b01;
        end else if (STRICT && n > 16) begin
            e_err = 1; m_code = 2'b10;
        end else if (w[15] && w[12]) begin
            e_err = 1; m_code = 2'b11;
        end else begin
            e_done = 1;
            m_spd  = w[14];
            m_pwr  = w[13];
            if (!w[15] && !w[12]) begin
                m_b = w[11:0]; m_buf = w[11:0];
            end else if (!w[15] && w[12]) begin
                m_buf = w[11:0];
            end else begin
                m_b = m_buf; m_a = w[11:0];
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dac_a"},    32'(dac_a),    32'(m_a));
        check({tag, "_dac_b"},    32'(dac_b),    32'(m_b));
        check({tag, "_dac_buf"},  32'(dac_buf),  32'(m_buf));
        check({tag, "_spd"},      32'(spd),      32'(m_spd));
        check({tag, "_pwr"},      32'(pwr),      32'(m_pwr));
        check({tag, "_err_code"}, 32'(err_code), 32'(m_code));
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.din  = bits[i];
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // Pulses inside the first 4 clocks after cs_n rises are on time; later ones are counted as late.
    task automatic watch_pulses(output int nd, output int ne, output int late);
        nd = 0; ne = 0; late = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                nd += int'(frame_done);
                ne += int'(frame_err);
            end else begin
                late += int'(frame_done) + int'(frame_err);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input string tag);
        int nd, ne, late;
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_busy_open"}, 32'(busy), 32'd1);
        shift_bits(bits, n);
        bus.cs_n = 1'b1;
        watch_pulses(nd, ne, late);
        model_frame(bits, n);
        check({tag, "_done"}, 32'(nd), 32'(e_done));
        check({tag, "_err"},  32'(ne), 32'(e_err));
        check({tag, "_late"}, 32'(late), 32'd0);
        check({tag, "_busy_closed"}, 32'(busy), 32'd0);
        check_state(tag);
    endtask

    initial begin
        int nd, ne, late;
        int len_tab [7] = '{14, 15, 16, 16, 16, 17, 18};
        rst      = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.din  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("in_reset");
        check("in_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_state("post_reset");

        send_frame(32'hCAAA, 16, "cmd_a");
        send_frame(32'h4555, 16, "cmd_b");
        send_frame(32'h1123, 16, "cmd_buf");
        send_frame(32'h8321, 16, "cmd_a_xfer");
        send_frame(32'h9FFF, 16, "reserved");
        send_frame(32'h4555, 15, "short");
        send_frame(32'h34ABC, 18, "long");

        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(32'hCA, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        bus.cs_n = 1'b1;
        watch_pulses(nd, ne, late);
        model_reset();
        check("abort_pulses", 32'(nd + ne + late), 32'd0);
        check_state("abort");
        repeat (4) @(negedge clk);
        send_frame(32'h4555, 16, "after_abort");

        for (int k = 0; k < 60; k++) begin
            int n;
            n = len_tab[$urandom_range(0, 6)];
            send_frame($urandom, n, $sformatf("rnd%0d_n%0d", k, n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
